// File: rtl/can_bit_destuffer.sv
// CAN bit destuffer: classifies each sampled bit as data or stuff, checks stuffing, counts FD stuff bits.
// Latency: one clk from the sample_pt strobe to every output.
// Backpressure: none; it follows the bus bit rate and expects one sample at most every clk.
module can_bit_destuffer #(
  parameter int STUFF_LEN = 5,
  parameter int FIXED_LEN = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sample_pt,
  input  logic       can_rx,
  input  logic       bs_on,
  input  logic       fixed_mode,
  input  logic       frame_clr,
  output logic       bit_out,
  output logic       bit_valid,
  output logic       is_stuff,
  output logic       stuff_err,
  output logic [2:0] stuff_cnt,
  output logic [2:0] stuff_gray,
  output logic       stuff_par
);

  localparam int RUN_W = $clog2(STUFF_LEN + 1);
  localparam int FIX_W = $clog2(FIXED_LEN + 1);

  logic             r_last_bit, w_last_bit;
  logic [RUN_W-1:0] r_run_len, w_run_len;
  logic             r_pending, w_pending;
  logic             r_fixed_active, w_fixed_active;
  logic [FIX_W-1:0] r_fixed_cnt, w_fixed_cnt;
  logic             r_bit_out, w_bit_out;
  logic             r_bit_valid, w_bit_valid;
  logic             r_is_stuff, w_is_stuff;
  logic             r_err, w_err;
  logic [2:0]       r_cnt, w_cnt;
  logic [2:0]       r_gray;
  logic             r_par;
  logic [RUN_W-1:0] w_run_eff;
  logic             w_pend_eff;

  // Next-state decode: frame_clr beats a coincident sample; a latched error freezes everything but bit_out.
  always_comb begin
    w_last_bit     = r_last_bit;
    w_run_len      = r_run_len;
    w_pending      = r_pending;
    w_fixed_active = r_fixed_active;
    w_fixed_cnt    = r_fixed_cnt;
    w_bit_out      = r_bit_out;
    w_bit_valid    = 1'b0;
    w_is_stuff     = r_is_stuff;
    w_err          = r_err;
    w_cnt          = r_cnt;
    // Leaving the fixed region restarts dynamic stuffing with a run of one.
    w_run_eff      = r_fixed_active ? RUN_W'(1) : r_run_len;
    w_pend_eff     = r_fixed_active ? 1'b0 : r_pending;
    if (frame_clr) begin
      w_last_bit     = 1'b0;
      w_run_len      = RUN_W'(1);
      w_pending      = 1'b0;
      w_fixed_active = 1'b0;
      w_fixed_cnt    = '0;
      w_is_stuff     = 1'b0;
      w_err          = 1'b0;
      w_cnt          = 3'd0;
    end else if (sample_pt) begin
      w_bit_out  = can_rx;
      w_is_stuff = 1'b0;
      if (r_err) begin
        // Stay silent until the next frame; only bit_out follows the bus.
      end else if (!bs_on) begin
        w_bit_valid    = 1'b1;
        w_last_bit     = can_rx;
        w_run_len      = RUN_W'(1);
        w_pending      = 1'b0;
        w_fixed_active = 1'b0;
      end else if (fixed_mode) begin
        if (!r_fixed_active || (r_fixed_cnt == FIX_W'(FIXED_LEN))) begin
          // Fixed stuff bit; it also replaces any dynamic stuff bit still owed.
          w_fixed_active = 1'b1;
          w_fixed_cnt    = '0;
          w_pending      = 1'b0;
          w_last_bit     = can_rx;
          if (can_rx == r_last_bit) w_err = 1'b1;
          else                      w_is_stuff = 1'b1;
        end else begin
          w_bit_valid = 1'b1;
          w_fixed_cnt = r_fixed_cnt + FIX_W'(1);
          w_last_bit  = can_rx;
        end
      end else begin
        w_fixed_active = 1'b0;
        if (w_pend_eff) begin
          if (can_rx == r_last_bit) begin
            w_err = 1'b1;
          end else begin
            w_is_stuff = 1'b1;
            w_cnt      = r_cnt + 3'd1;
            w_last_bit = can_rx;
            w_run_len  = RUN_W'(1);
            w_pending  = 1'b0;
          end
        end else begin
          w_bit_valid = 1'b1;
          w_run_len   = (can_rx == r_last_bit) ? (w_run_eff + RUN_W'(1)) : RUN_W'(1);
          w_pending   = (w_run_len >= RUN_W'(STUFF_LEN));
          w_last_bit  = can_rx;
        end
      end
    end
  end

  // State and output registers; Gray code and parity are derived from the next count so all three agree.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_last_bit     <= 1'b1;
      r_run_len      <= '0;
      r_pending      <= 1'b0;
      r_fixed_active <= 1'b0;
      r_fixed_cnt    <= '0;
      r_bit_out      <= 1'b0;
      r_bit_valid    <= 1'b0;
      r_is_stuff     <= 1'b0;
      r_err          <= 1'b0;
      r_cnt          <= 3'd0;
      r_gray         <= 3'd0;
      r_par          <= 1'b0;
    end else begin
      r_last_bit     <= w_last_bit;
      r_run_len      <= w_run_len;
      r_pending      <= w_pending;
      r_fixed_active <= w_fixed_active;
      r_fixed_cnt    <= w_fixed_cnt;
      r_bit_out      <= w_bit_out;
      r_bit_valid    <= w_bit_valid;
      r_is_stuff     <= w_is_stuff;
      r_err          <= w_err;
      r_cnt          <= w_cnt;
      r_gray         <= w_cnt ^ (w_cnt >> 1);
      r_par          <= ^(w_cnt ^ (w_cnt >> 1));
    end
  end

  assign bit_out    = r_bit_out;
  assign bit_valid  = r_bit_valid;
  assign is_stuff   = r_is_stuff;
  assign stuff_err  = r_err;
  assign stuff_cnt  = r_cnt;
  assign stuff_gray = r_gray;
  assign stuff_par  = r_par;

endmodule
